bit_stream_serializer: RTL and testbench

Upstream feeder for the serial sequence-detector stage. Accepts parallel words over a valid/ready handshake, buffers one word, and shifts each word out one bit at a time at a programmable bit period. The serial output drives the detector's 1-bit input, `ui_in[0]`. Back-to-back words stream with no gap bits. The line idles at 0 so the detector returns to its initial state between bursts.

---
 rtl/bit_stream_serializer.sv | 96 +++++++++
 tb/tb_bit_stream_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder: one-word holding register in front of a shifter with a programmable bit period.
// Words stream gaplessly when the holding register refills before the last bit ends; the line idles at 0.
module bit_stream_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] div,
  input  logic             lsb_first,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_strobe,
  output logic             word_done,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] sh_q;
  logic [BW-1:0]    bidx_q;
  logic [DIV_W-1:0] dcnt_q;
  logic [DIV_W-1:0] div_q;
  logic             lsb_q;

  logic shifting, bit_end, last_end, load_d, accept_d;

  assign shifting = (state_q == SHIFT);
  assign bit_end  = (dcnt_q == div_q);
  assign last_end = shifting && bit_end && (bidx_q == LAST);
  // The shifter takes the held word when idle or exactly at the end of the current word's last bit.
  assign load_d   = hold_full_q && (!shifting || last_end);
  assign accept_d = in_valid && !hold_full_q;

  assign in_ready   = !hold_full_q;
  assign busy       = shifting;
  assign bit_out    = shifting && (lsb_q ? sh_q[bidx_q] : sh_q[LAST - bidx_q]);
  assign bit_strobe = shifting && (dcnt_q == '0);
  assign word_done  = last_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      bidx_q      <= '0;
      dcnt_q      <= '0;
      div_q       <= '0;
      lsb_q       <= 1'b0;
    end else if (abort) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      bidx_q      <= '0;
      dcnt_q      <= '0;
    end else begin
      if (accept_d) begin
        hold_q      <= in_data;
        hold_full_q <= 1'b1;
      end else if (load_d) begin
        hold_full_q <= 1'b0;
      end

      if (load_d) begin
        state_q <= SHIFT;
        sh_q    <= hold_q;
        bidx_q  <= '0;
        dcnt_q  <= '0;
        div_q   <= div;
        lsb_q   <= lsb_first;
      end else if (shifting) begin
        if (!bit_end) begin
          dcnt_q <= dcnt_q + 1'b1;
        end else begin
          dcnt_q <= '0;
          if (bidx_q == LAST) begin
            state_q <= IDLE;
            bidx_q  <= '0;
          end else begin
            bidx_q <= bidx_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: directed scenarios then random traffic, checked every cycle
// against a model that expands each loaded word into its expected per-cycle waveform.
module tb_bit_stream_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] div = '0;
  logic       lsb_first = 1'b0;
  logic       abort = 1'b0;
  logic       bit_out, bit_strobe, word_done, busy;

  bit_stream_serializer #(.WIDTH(8), .DIV_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div        (div),
    .lsb_first  (lsb_first),
    .abort      (abort),
    .bit_out    (bit_out),
    .bit_strobe (bit_strobe),
    .word_done  (word_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: wave holds {bit, strobe} for every remaining cycle of the word on the line.
  logic [1:0] wave[$];
  logic       m_hf = 1'b0;
  logic [7:0] m_hold = '0;
  logic       m_acc;
  logic [15:0] cap;
  int          dcount;

  task automatic expand(input logic [7:0] w, input logic [7:0] dv, input logic lsb);
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = lsb ? i : 7 - i;
      for (int c = 0; c <= int'(dv); c++) wave.push_back({w[idx], c == 0});
    end
  endtask

  task automatic model_edge(input logic vld, input logic [7:0] d, input logic [7:0] dv,
                            input logic lsb, input logic ab, input logic r);
    logic had_hf;
    m_acc = 1'b0;
    if (r || ab) begin
      wave.delete();
      m_hf = 1'b0;
      if (r) m_hold = '0;
    end else begin
      had_hf = m_hf;
      if (wave.size() > 0) void'(wave.pop_front());
      if (had_hf && wave.size() == 0) begin
        expand(m_hold, dv, lsb);
        m_hf = 1'b0;
      end else if (vld && !had_hf) begin
        m_hold = d;
        m_hf   = 1'b1;
        m_acc  = 1'b1;
      end
    end
  endtask

  task automatic step(input logic vld, input logic [7:0] d, input logic [7:0] dv,
                      input logic lsb, input logic ab, input logic r);
    logic eb, es;
    @(negedge clk);
    eb = (wave.size() > 0) ? wave[0][1] : 1'b0;
    es = (wave.size() > 0) ? wave[0][0] : 1'b0;
    chk("bit_out",    32'(bit_out),    32'(eb));
    chk("bit_strobe", 32'(bit_strobe), 32'(es));
    chk("word_done",  32'(word_done),  32'(wave.size() == 1));
    chk("busy",       32'(busy),       32'(wave.size() > 0));
    chk("in_ready",   32'(in_ready),   32'(!m_hf));
    if (bit_strobe) cap = {cap[14:0], bit_out};
    if (word_done) dcount++;
    in_valid  = vld;
    in_data   = d;
    div       = dv;
    lsb_first = lsb;
    abort     = ab;
    rst       = r;
    model_edge(vld, d, dv, lsb, ab, r);
  endtask

  task automatic idle(input int n, input logic [7:0] dv, input logic lsb);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, dv, lsb, 1'b0, 1'b0);
  endtask

  // Hold in_valid with word d until the model says it was accepted.
  task automatic send(input logic [7:0] d, input logic [7:0] dv, input logic lsb);
    int n;
    n = 0;
    do begin
      step(1'b1, d, dv, lsb, 1'b0, 1'b0);
      n++;
    end while (!m_acc && n < 200);
    if (!m_acc) chk("send_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    // Reset with in_valid high: nothing may be accepted or shifted.
    step(1'b1, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(6, 8'h00, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 0xD6, div=0, MSB first.
    cap = '0; dcount = 0;
    send(8'hD6, 8'h00, 1'b0);
    idle(12, 8'h00, 1'b0);
    chk("d6_bits", 32'(cap[7:0]), 32'hD6);
    chk("d6_done", 32'(dcount), 32'd1);

    // 0x80, div=2: eight 3-cycle bits.
    cap = '0; dcount = 0;
    send(8'h80, 8'h02, 1'b0);
    idle(30, 8'h02, 1'b0);
    chk("x80_bits", 32'(cap[7:0]), 32'h80);
    chk("x80_done", 32'(dcount), 32'd1);

    // Back-to-back 0xA5, 0x3C.
    cap = '0; dcount = 0;
    send(8'hA5, 8'h00, 1'b0);
    send(8'h3C, 8'h00, 1'b0);
    idle(20, 8'h00, 1'b0);
    chk("b2b_bits", 32'(cap), 32'hA53C);
    chk("b2b_done", 32'(dcount), 32'd2);

    // LSB first with a mid-word request for MSB first.
    cap = '0; dcount = 0;
    send(8'h01, 8'h00, 1'b1);
    idle(3, 8'h00, 1'b1);
    idle(12, 8'h00, 1'b0);
    chk("lsb_bits", 32'(cap[7:0]), 32'h80);

    // Abort during bit 3 of 0xFF while 0x55 waits.
    cap = '0; dcount = 0;
    send(8'hFF, 8'h01, 1'b0);
    send(8'h55, 8'h01, 1'b0);
    idle(3, 8'h01, 1'b0);
    step(1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
    idle(30, 8'h01, 1'b0);
    chk("abort_done", 32'(dcount), 32'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom_range(0, 3)),
           1'($urandom), ($urandom_range(0, 79) == 0), ($urandom_range(0, 299) == 0));
    end
    idle(40, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
